// File: rtl/mac_acumulador.sv
// mac_acumulador: sequential signed multiply-accumulate.
// Takes TAPS sample/coefficient pairs after a Start and multiplies each pair.
// The products are summed at full 2N-bit precision, wrapping modulo 2^(2N).
// The finished sum is registered on Datos_Sum and announced by a one-cycle
// Sum_Listo strobe.
module mac_acumulador #(
    parameter int N    = 25,
    parameter int TAPS = 5
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           Start,
    input  logic [N-1:0]   Dato_A,
    input  logic [N-1:0]   Dato_B,
    input  logic           Dato_Valido,
    output logic [2*N-1:0] Datos_Sum,
    output logic           Sum_Listo,
    output logic           Ocupado
);

    localparam int CW = (TAPS < 2) ? 1 : $clog2(TAPS + 1);
    localparam logic [CW-1:0] LAST_PAIR = CW'(TAPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACUM,
        DRENAR
    } state_t;

    state_t          state_q, state_d;
    logic [2*N-1:0]  acc_q, acc_d;
    logic [2*N-1:0]  p_q, p_d;
    logic            p_valid_q, p_valid_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2*N-1:0]  sum_q, sum_d;
    logic            listo_q, listo_d;

    logic signed [2*N-1:0] a_ext;
    logic signed [2*N-1:0] b_ext;
    logic signed [2*N-1:0] product;

    // The operands are sign-extended to 2N bits. The signed product of two
    // N-bit values always fits in 2N bits, so truncating the result is exact.
    always_comb begin
        a_ext   = {{N{Dato_A[N-1]}}, Dato_A};
        b_ext   = {{N{Dato_B[N-1]}}, Dato_B};
        product = a_ext * b_ext;
    end

    // Next-state logic for the FSM and the datapath.
    // A registered product is folded into the accumulator on the following
    // edge. DRENAR waits for the last product to be absorbed, then publishes
    // the accumulator.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        p_d       = p_q;
        p_valid_d = 1'b0;
        count_d   = count_q;
        sum_d     = sum_q;
        listo_d   = 1'b0;

        if (p_valid_q) begin
            acc_d = acc_q + p_q;
        end

        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = ACUM;
                    acc_d   = '0;
                    p_d     = '0;
                    count_d = '0;
                end
            end
            ACUM: begin
                if (Dato_Valido) begin
                    p_d       = product;
                    p_valid_d = 1'b1;
                    count_d   = count_q + CW'(1);
                    if (count_q == LAST_PAIR) begin
                        state_d = DRENAR;
                    end
                end
            end
            DRENAR: begin
                if (!p_valid_q) begin
                    sum_d   = acc_q;
                    listo_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset discards any partial result.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            p_q       <= '0;
            p_valid_q <= 1'b0;
            count_q   <= '0;
            sum_q     <= '0;
            listo_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            p_q       <= p_d;
            p_valid_q <= p_valid_d;
            count_q   <= count_d;
            sum_q     <= sum_d;
            listo_q   <= listo_d;
        end
    end

    assign Datos_Sum = sum_q;
    assign Sum_Listo = listo_q;
    assign Ocupado   = (state_q != IDLE);

endmodule

// File: tb/tb_mac_acumulador.sv
// Directed testbench for mac_acumulador.
module tb_mac_acumulador;

    localparam int N    = 25;
    localparam int TAPS = 5;

    logic           CLK;
    logic           RST_N;
    logic           Start;
    logic [N-1:0]   Dato_A;
    logic [N-1:0]   Dato_B;
    logic           Dato_Valido;
    logic [2*N-1:0] Datos_Sum;
    logic           Sum_Listo;
    logic           Ocupado;

    int errors = 0;
    int checks = 0;

    mac_acumulador #(.N(N), .TAPS(TAPS)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .Start       (Start),
        .Dato_A      (Dato_A),
        .Dato_B      (Dato_B),
        .Dato_Valido (Dato_Valido),
        .Datos_Sum   (Datos_Sum),
        .Sum_Listo   (Sum_Listo),
        .Ocupado     (Ocupado)
    );

    // Free-running 10-time-unit clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Drive one cycle of inputs, let a rising edge pass, and settle 1 unit.
    task automatic applyStimulus(input logic s, input logic v, input int a, input int b);
        Start       = s;
        Dato_Valido = v;
        Dato_A      = N'(a);
        Dato_B      = N'(b);
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [63:0] sum, input logic listo, input logic busy);
        checkOutput({tag, ".Datos_Sum"}, 64'(Datos_Sum), sum);
        checkOutput({tag, ".Sum_Listo"}, 64'(Sum_Listo), 64'(listo));
        checkOutput({tag, ".Ocupado"}, 64'(Ocupado), 64'(busy));
    endtask

    initial begin
        RST_N       = 1'b1;
        Start       = 1'b0;
        Dato_Valido = 1'b0;
        Dato_A      = '0;
        Dato_B      = '0;

        // Asynchronous reset mid-cycle: outputs clear without a clock edge.
        #3 RST_N = 1'b0;
        #1 checkAll("reset_async", 64'd0, 1'b0, 1'b0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        RST_N = 1'b1;

        // Idle for 5 cycles with Dato_Valido pulses, which must be ignored.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, (i % 2 == 0), 100 + i, 7);
            checkAll($sformatf("idle%0d", i), 64'd0, 1'b0, 1'b0);
        end

        // Basic: the sum of pairs (1,2)..(9,10) is 190.
        applyStimulus(1, 0, 0, 0);
        checkAll("basic_start", 64'd0, 1'b0, 1'b1);
        for (int i = 0; i < TAPS; i++) begin
            applyStimulus(0, 1, 2 * i + 1, 2 * i + 2);
            checkAll($sformatf("basic_pair%0d", i), 64'd0, 1'b0, 1'b1);
        end
        applyStimulus(0, 0, 0, 0);
        checkAll("basic_k1", 64'd0, 1'b0, 1'b1);
        applyStimulus(0, 0, 0, 0);
        checkAll("basic_k2", 64'd190, 1'b1, 1'b0);
        applyStimulus(0, 0, 0, 0);
        checkAll("basic_k3", 64'd190, 1'b0, 1'b0);

        // Signed with gaps: 5 x (-1,5) = -25. Only valid pairs are counted.
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < TAPS; i++) begin
            applyStimulus(0, 1, -1, 5);
            if (i < TAPS - 1) begin
                for (int g = 0; g <= (i % 3); g++) begin
                    applyStimulus(0, 0, 77, 77);
                    checkAll($sformatf("gap%0d_%0d", i, g), 64'd190, 1'b0, 1'b1);
                end
            end
        end
        applyStimulus(0, 0, 0, 0);
        checkAll("signed_k1", 64'd190, 1'b0, 1'b1);
        applyStimulus(0, 0, 0, 0);
        checkAll("signed_k2", 64'h0003_FFFF_FFFF_FFE7, 1'b1, 1'b0);
        applyStimulus(0, 0, 0, 0);

        // Wrap-around: 5 x (-2^24,-2^24) = 5*2^48, which wraps to 2^48.
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < TAPS; i++) begin
            applyStimulus(0, 1, -(1 << 24), -(1 << 24));
        end
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkAll("wrap_k2", 64'h0001_0000_0000_0000, 1'b1, 1'b0);
        applyStimulus(0, 0, 0, 0);

        // Busy rules: Start during ACUM and on the Sum_Listo cycle are ignored.
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < TAPS; i++) begin
            applyStimulus((i == 2), 1, 1, 1);
        end
        applyStimulus(0, 0, 0, 0);
        checkAll("busy_k1", 64'h0001_0000_0000_0000, 1'b0, 1'b1);
        applyStimulus(1, 0, 0, 0);
        checkAll("busy_k2", 64'd5, 1'b1, 1'b0);
        applyStimulus(1, 0, 0, 0);
        checkAll("busy_k3_restart", 64'd5, 1'b0, 1'b1);
        for (int i = 0; i < TAPS; i++) begin
            applyStimulus(0, 1, 2, 2);
            checkAll($sformatf("hold%0d", i), 64'd5, 1'b0, 1'b1);
        end
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkAll("rerun_k2", 64'd20, 1'b1, 1'b0);
        applyStimulus(0, 0, 0, 0);

        // Reset after 3 of 5 pairs, then a clean run of 5 x (2,3) = 30.
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 7, 7);
        end
        #2 RST_N = 1'b0;
        #1 checkAll("reset_mid", 64'd0, 1'b0, 1'b0);
        applyStimulus(0, 1, 7, 7);
        RST_N = 1'b1;
        applyStimulus(0, 0, 0, 0);
        checkAll("reset_idle", 64'd0, 1'b0, 1'b0);
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < TAPS; i++) begin
            applyStimulus(0, 1, 2, 3);
        end
        applyStimulus(0, 0, 0, 0);
        checkAll("post_reset_k1", 64'd0, 1'b0, 1'b1);
        applyStimulus(0, 0, 0, 0);
        checkAll("post_reset_k2", 64'd30, 1'b1, 1'b0);
        applyStimulus(0, 0, 0, 0);
        checkAll("post_reset_k3", 64'd30, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
